// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shifts modulo DATA_WIDTH and pulses frame_done on the wrapping shift.
module shift_frame_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with serial taps at both ends and per-frame shift counting.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  ser_in_r,
  input  logic                  ser_in_l,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic [DATA_WIDTH-1:0] par_out,
  output logic                  ser_out_r,
  output logic                  ser_out_l,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  frame_done
);

  logic [DATA_WIDTH-1:0] q_q, q_d;
  mode_e                 mode_w;
  logic                  shift_w, load_w;

  assign mode_w  = mode_e'(mode);
  assign shift_w = en && (mode_w == MODE_SHR || mode_w == MODE_SHL);
  assign load_w  = en && (mode_w == MODE_LOAD);

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_w)
        MODE_SHR:  q_d = {ser_in_r, q_q[DATA_WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[DATA_WIDTH-2:0], ser_in_l};
        MODE_LOAD: q_d = par_in;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  // Counter shares the data register's reset so a mid-frame reset abandons the frame.
  shift_frame_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (shift_w),
    .clr        (load_w),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  assign par_out   = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed plus randomized checks of universal_shift_register against an
// arithmetic model (integer register value, running shift total).
module tb_universal_shift_register;

  localparam int DW = 8;
  localparam logic [1:0] HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst, en, ser_in_r, ser_in_l;
  logic [1:0]    mode;
  logic [DW-1:0] par_in, par_out;
  logic          ser_out_r, ser_out_l, frame_done;
  logic [2:0]    shift_cnt;

  int passed = 0;
  int total  = 0;

  int unsigned m_q;
  int          m_shifts;
  bit          m_done;

  universal_shift_register #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .ser_in_r   (ser_in_r),
    .ser_in_l   (ser_in_l),
    .par_in     (par_in),
    .par_out    (par_out),
    .ser_out_r  (ser_out_r),
    .ser_out_l  (ser_out_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [DW-1:0] p);
    rst = r; en = e; mode = m; ser_in_r = sr; ser_in_l = sl; par_in = p;
    @(posedge clk); #1;
    if (!r) begin
      m_q = 0; m_shifts = 0; m_done = 0;
    end else if (!e || m == HOLD) begin
      m_done = 0;
    end else if (m == LOAD) begin
      m_q = p; m_shifts = 0; m_done = 0;
    end else begin
      if (m == SHR) m_q = (m_q / 2) + (sr ? 128 : 0);
      else          m_q = (m_q * 2 + (sl ? 1 : 0)) % 256;
      m_shifts++;
      m_done = (m_shifts % DW) == 0;
    end
    chk("par_out",    32'(par_out),    32'(m_q));
    chk("ser_out_r",  32'(ser_out_r),  32'(m_q % 2));
    chk("ser_out_l",  32'(ser_out_l),  32'(m_q / 128));
    chk("shift_cnt",  32'(shift_cnt),  32'(m_shifts % DW));
    chk("frame_done", 32'(frame_done), 32'(m_done));
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic [3:0]    shl_bits;
    int unsigned   rv;
    rst = 1'b0; en = 1'b1; mode = LOAD; ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 8'hFF;
    m_q = 0; m_shifts = 0; m_done = 0;

    // Reset dominates LOAD
    step(0, 1, LOAD, 0, 0, 8'hFF);
    step(0, 1, LOAD, 0, 0, 8'hFF);
    chk("reset_par_out", 32'(par_out), 32'h00);

    // LOAD A5, shift out right
    step(1, 1, LOAD, 0, 0, 8'hA5);
    a5 = 8'hA5;
    for (int i = 0; i < DW; i++) begin
      chk("shr_ser_out_r_seq", 32'(ser_out_r), 32'(a5[i]));
      step(1, 1, SHR, 0, 0, 8'h00);
    end
    chk("shr_frame_par_out", 32'(par_out), 32'h00);
    chk("shr_frame_done", 32'(frame_done), 32'd1);
    step(1, 1, HOLD, 0, 0, 8'h00);
    chk("shr_frame_done_clear", 32'(frame_done), 32'd0);

    // SHL serial in 1,1,0,1
    shl_bits = 4'b1011;
    for (int i = 0; i < 4; i++) step(1, 1, SHL, 0, shl_bits[i], 8'h00);
    chk("shl_par_out", 32'(par_out), 32'h0D);
    chk("shl_cnt", 32'(shift_cnt), 32'd4);

    // Enable / hold gaps
    step(1, 1, LOAD, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 1, SHR, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, SHR, 1, 0, 8'h00);
    chk("gap_cnt_en0", 32'(shift_cnt), 32'd3);
    for (int i = 0; i < 2; i++) step(1, 1, HOLD, 1, 0, 8'h00);
    chk("gap_cnt_hold", 32'(shift_cnt), 32'd3);
    for (int i = 0; i < 5; i++) step(1, 1, SHR, 1, 0, 8'h00);
    chk("gap_frame_done", 32'(frame_done), 32'd1);
    chk("gap_par_out", 32'(par_out), 32'hFF);

    // Mid-frame LOAD and mid-frame reset
    for (int i = 0; i < 5; i++) step(1, 1, SHL, 0, 1, 8'h00);
    step(1, 1, LOAD, 0, 0, 8'h3C);
    chk("midload_par_out", 32'(par_out), 32'h3C);
    chk("midload_cnt", 32'(shift_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 1, SHR, 1, 0, 8'h00);
    step(0, 1, SHR, 1, 0, 8'h00);
    chk("midrst_par_out", 32'(par_out), 32'h00);
    chk("midrst_done", 32'(frame_done), 32'd0);

    // Streaming, pure SHR then with SHL at shifts 3-4
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3 * DW; i++) begin
        step(1, 1, (pass == 1 && (i == 2 || i == 3)) ? SHL : SHR, i[0], i[1], 8'h00);
        chk("stream_done", 32'(frame_done), 32'((i % DW) == DW - 1));
      end
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = $urandom;
      step((rv % 64) != 0, (rv[8:6] != 3'd0), rv[10:9], rv[11], rv[12], rv[20:13]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
